// File: rtl/servo_sweep_pkg.sv
// Shared types and constants for the servo sweep controller.
// Imported by the top and the step calculator.
package servo_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_WAIT
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [31:0] TARGET_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sweep_step_calc.sv
// Next sweep position and direction from the current one.
// 33-bit sums keep the bounds from wrapping near 2^32.
module sweep_step_calc
    import servo_sweep_pkg::*;
(
    input  logic [31:0] pos_i,
    input  logic [31:0] min_i,
    input  logic [31:0] max_i,
    input  logic [15:0] step_i,
    input  logic        up_i,
    output logic [31:0] pos_o,
    output logic        up_o
);

    logic [32:0] inc;
    logic [32:0] lim;

    assign inc = {1'b0, pos_i} + {17'd0, step_i};
    assign lim = {1'b0, min_i} + {17'd0, step_i};

    // Bounce between the bounds; a degenerate range pins at min.
    always_comb begin
        pos_o = pos_i;
        up_o  = up_i;
        if (min_i >= max_i) begin
            pos_o = min_i;
            up_o  = 1'b1;
        end else if (up_i) begin
            if (inc >= {1'b0, max_i}) begin
                pos_o = max_i;
                up_o  = 1'b0;
            end else begin
                pos_o = inc[31:0];
            end
        end else begin
            if ({1'b0, pos_i} <= lim) begin
                pos_o = min_i;
                up_o  = 1'b1;
            end else begin
                pos_o = pos_i - {16'd0, step_i};
            end
        end
    end

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Sweeps a servo duty register between two bounds using
// single AXI4-Lite writes spaced by a programmable idle period.
module servo_sweep_ctrl
    import servo_sweep_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] TARGET_ADDR =
        C_M_AXI_ADDR_WIDTH'(TARGET_ADDR_DEFAULT)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          start,
    input  logic                          stop,
    input  logic [31:0]                   min_val,
    input  logic [31:0]                   max_val,
    input  logic [15:0]                   step,
    input  logic [31:0]                   period,
    output logic                          busy,
    output logic                          err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    state_e      state_q, state_d;
    logic [31:0] pos_q, pos_d;
    logic        up_q, up_d;
    logic [31:0] min_q, min_d;
    logic [31:0] max_q, max_d;
    logic [15:0] step_q, step_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic        awv_q, awv_d;
    logic        wv_q, wv_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;

    logic [31:0] calc_pos;
    logic        calc_up;

    sweep_step_calc u_calc (
        .pos_i  (pos_q),
        .min_i  (min_q),
        .max_i  (max_q),
        .step_i (step_q),
        .up_i   (up_q),
        .pos_o  (calc_pos),
        .up_o   (calc_up)
    );

    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;
    assign M_AXI_AWADDR  = TARGET_ADDR;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awv_q;
    assign M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(pos_q);
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wv_q;
    assign M_AXI_BREADY  = (state_q == ST_RESP);

    // Sequencer: issue write, collect response, idle, repeat.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        up_d     = up_q;
        min_d    = min_q;
        max_d    = max_q;
        step_d   = step_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        awv_d    = awv_q;
        wv_d     = wv_q;
        err_d    = err_q;
        pend_d   = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    min_d    = min_val;
                    max_d    = max_val;
                    step_d   = step;
                    period_d = period;
                    pos_d    = min_val;
                    up_d     = 1'b1;
                    err_d    = 1'b0;
                    pend_d   = 1'b0;
                    awv_d    = 1'b1;
                    wv_d     = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (awv_q && M_AXI_AWREADY) awv_d = 1'b0;
                if (wv_q && M_AXI_WREADY) wv_d = 1'b0;
                if (stop) pend_d = 1'b1;
                if (!awv_d && !wv_d) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (stop) pend_d = 1'b1;
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) err_d = 1'b1;
                    pos_d  = calc_pos;
                    up_d   = calc_up;
                    pend_d = 1'b0;
                    if (pend_q || stop) begin
                        state_d = ST_IDLE;
                    end else if (period_q == 32'd0) begin
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        cnt_d   = period_q;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= 32'd1) begin
                    cnt_d   = 32'd0;
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            pos_q    <= 32'd0;
            up_q     <= 1'b1;
            min_q    <= 32'd0;
            max_q    <= 32'd0;
            step_q   <= 16'd0;
            period_q <= 32'd0;
            cnt_q    <= 32'd0;
            awv_q    <= 1'b0;
            wv_q     <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            up_q     <= up_d;
            min_q    <= min_d;
            max_q    <= max_d;
            step_q   <= step_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            awv_q    <= awv_d;
            wv_q     <= wv_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Bench for servo_sweep_ctrl: AXI4-Lite slave model with
// configurable stalls and a reference sweep model.
module tb_servo_sweep_ctrl;

    localparam logic [31:0] TA = 32'h4000_0010;

    logic        ACLK;
    logic        ARESETN;
    logic        start;
    logic        stop;
    logic [31:0] min_val;
    logic [31:0] max_val;
    logic [15:0] step;
    logic [31:0] period;
    logic        busy;
    logic        err;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    servo_sweep_ctrl #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .TARGET_ADDR        (TA)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .stop          (stop),
        .min_val       (min_val),
        .max_val       (max_val),
        .step          (step),
        .period        (period),
        .busy          (busy),
        .err           (err),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int aw_delay = 0;
    int w_delay  = 0;
    int bad_idx  = 0;
    bit b_hold   = 0;
    bit aw_seen  = 0;
    bit w_seen   = 0;
    int aw_wait  = 0;
    int w_wait   = 0;
    int w_count  = 0;
    int b_cnt    = 0;
    int aw_rise  = 0;
    int cyc      = 0;
    int b_cyc    = -1;
    logic awv_prev = 1'b0;
    int gaps[$];
    logic [31:0] wq[$];
    longint exp_q[$];
    int unsigned t31[8] = '{100, 110, 120, 130, 120, 110, 100, 110};

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave bookkeeping on the active edge (pre-edge DUT values).
    always @(posedge ACLK) begin
        cyc++;
        if (!ARESETN) begin
            aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0;
            awv_prev = 1'b0; b_cyc = -1;
        end else begin
            if (aw_seen) chk("aw_drop", 64'(M_AXI_AWVALID), 64'd0);
            if (w_seen) chk("w_drop", 64'(M_AXI_WVALID), 64'd0);
            if (M_AXI_AWVALID && !awv_prev) begin
                aw_rise++;
                if (b_cyc >= 0) gaps.push_back(cyc - b_cyc - 1);
                b_cyc = -1;
            end
            awv_prev = M_AXI_AWVALID;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_seen = 1;
                chk("awaddr", 64'(M_AXI_AWADDR), 64'(TA));
                chk("awprot", 64'(M_AXI_AWPROT), 64'd0);
            end else if (M_AXI_AWVALID) begin
                aw_wait++;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_seen = 1;
                w_count++;
                wq.push_back(M_AXI_WDATA);
                chk("wstrb", 64'(M_AXI_WSTRB), 64'hF);
            end else if (M_AXI_WVALID) begin
                w_wait++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                b_cnt++;
                b_cyc = cyc;
                aw_seen = 0; w_seen = 0; aw_wait = 0; w_wait = 0;
            end
        end
    end

    // Slave drives its inputs half a cycle away from the edge.
    always @(negedge ACLK) begin
        M_AXI_AWREADY = ARESETN && M_AXI_AWVALID && (aw_wait >= aw_delay);
        M_AXI_WREADY  = ARESETN && M_AXI_WVALID && (w_wait >= w_delay);
        M_AXI_BVALID  = ARESETN && aw_seen && w_seen && !b_hold;
        M_AXI_BRESP   = (w_count == bad_idx) ? 2'b10 : 2'b00;
    end

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic wait_b(input int n);
        int k = 0;
        while (b_cnt < n && k < 2000) begin
            tick();
            k++;
        end
        chk("b_timeout", 64'(b_cnt >= n), 64'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Reference sweep: bounce between bounds, clamp at the ends.
    task automatic build_model(input longint mn, input longint mx,
                               input longint st, input int n);
        longint p = mn;
        bit up = 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            if (mn >= mx) begin
                p = mn;
            end else if (up) begin
                if (p + st >= mx) begin p = mx; up = 0; end
                else p = p + st;
            end else begin
                if (p <= mn + st) begin p = mn; up = 1; end
                else p = p - st;
            end
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
        chk("rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
        chk("rst_bready", 64'(M_AXI_BREADY), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_awaddr", 64'(M_AXI_AWADDR), 64'(TA));
        chk("rst_wdata", 64'(M_AXI_WDATA), 64'd0);
        chk("rst_wstrb", 64'(M_AXI_WSTRB), 64'hF);
        chk("rst_awprot", 64'(M_AXI_AWPROT), 64'd0);
    endtask

    task automatic run(input longint mn, input longint mx, input int st,
                       input int per, input int nb, input int ad,
                       input int wd, input int bad);
        int n0;
        aw_delay = ad; w_delay = wd; bad_idx = bad; b_hold = 0;
        wq.delete(); gaps.delete();
        w_count = 0; b_cnt = 0; b_cyc = -1;
        min_val = 32'(mn); max_val = 32'(mx);
        step = 16'(st); period = 32'(per);
        start = 1;
        tick();
        start = 0;
        chk("busy_on", 64'(busy), 64'd1);
        chk("err_clear", 64'(err), 64'd0);
        min_val = $urandom; max_val = $urandom;
        step = 16'($urandom); period = $urandom;
        wait_b(2);
        start = 1;
        tick();
        start = 0;
        wait_b(nb);
        stop = 1;
        tick();
        stop = 0;
        wait_idle();
        n0 = wq.size();
        repeat (10) tick();
        chk("quiet_after_stop", 64'(wq.size()), 64'(n0));
        chk("enough_writes", 64'(wq.size() >= nb), 64'd1);
        build_model(mn, mx, longint'(st), wq.size());
        foreach (wq[i]) chk("wdata", 64'(wq[i]), 64'(exp_q[i]));
        chk("err_final", 64'(err), 64'(bad != 0 && bad <= b_cnt));
        foreach (gaps[i]) chk("idle_gap", 64'(gaps[i]), 64'(per));
    endtask

    initial begin
        int k;
        int r0;
        longint mn;
        longint mx;
        ARESETN = 0; start = 0; stop = 0;
        min_val = 0; max_val = 0; step = 0; period = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        #1;
        chk_reset_outs();
        tick(); tick();
        ARESETN = 1;
        tick();

        // Basic sweep with fixed spacing
        run(100, 130, 10, 2, 8, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            if (i < wq.size()) chk("sweep31", 64'(wq[i]), 64'(t31[i]));

        // Address accepted well before data
        run(5, 40, 7, 0, 4, 0, 3, 0);
        // Data accepted before address
        run(5, 40, 7, 1, 4, 3, 0, 0);
        // Error response on the second write, then cleared
        run(10, 20, 3, 1, 5, 1, 0, 2);
        run(10, 20, 3, 0, 3, 0, 0, 0);
        // Top-of-range clamp without wrap
        run(64'hFFFF_FFF0, 64'hFFFF_FFFF, 32'h20, 0, 4, 0, 0, 0);
        chk("top_w0", 64'(wq[0]), 64'hFFFF_FFF0);
        chk("top_w1", 64'(wq[1]), 64'hFFFF_FFFF);
        // Degenerate ranges and zero step
        run(50, 50, 5, 1, 3, 0, 0, 0);
        run(90, 40, 5, 0, 3, 1, 1, 0);
        run(77, 200, 0, 1, 3, 0, 0, 0);

        // Stop while the address is still outstanding
        aw_delay = 3; w_delay = 0; bad_idx = 0;
        wq.delete(); w_count = 0; b_cnt = 0; b_cyc = -1;
        min_val = 222; max_val = 400; step = 9; period = 0;
        start = 1;
        tick();
        start = 0;
        k = 0;
        while (!M_AXI_AWVALID && k < 20) begin tick(); k++; end
        chk("stop_awv_seen", 64'(M_AXI_AWVALID), 64'd1);
        stop = 1;
        tick();
        stop = 0;
        k = 0;
        while (!(M_AXI_BVALID && M_AXI_BREADY) && k < 50) begin
            tick();
            k++;
        end
        chk("stop_b_busy", 64'(busy), 64'd1);
        tick();
        chk("stop_idle", 64'(busy), 64'd0);
        r0 = aw_rise;
        repeat (20) tick();
        chk("stop_no_aw", 64'(aw_rise), 64'(r0));
        chk("stop_nwr", 64'(wq.size()), 64'd1);
        chk("stop_wdata", 64'(wq[0]), 64'd222);

        // Start and stop together: stop wins
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("ss_busy", 64'(busy), 64'd0);
        tick();
        chk("ss_no_aw", 64'(aw_rise), 64'(r0));

        // Randomized sweeps
        for (int r = 0; r < 6; r++) begin
            mn = $urandom_range(0, 500);
            if (r % 3 == 2) mx = $urandom_range(0, 500);
            else mx = mn + $urandom_range(0, 300);
            if (r == 4) begin
                mn = 32'hFFFF_FE00 + $urandom_range(0, 255);
                mx = 32'hFFFF_FFFF - $urandom_range(0, 64);
            end
            run(mn, mx, $urandom_range(0, 60), $urandom_range(0, 3),
                $urandom_range(3, 9), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 4));
        end

        // Reset while waiting for the response
        aw_delay = 0; w_delay = 0; bad_idx = 1; b_hold = 1;
        wq.delete(); w_count = 0;
        min_val = 300; max_val = 400; step = 10; period = 0;
        start = 1;
        tick();
        start = 0;
        k = 0;
        while (!M_AXI_BREADY && k < 50) begin tick(); k++; end
        chk("resp_reached", 64'(M_AXI_BREADY), 64'd1);
        ARESETN = 0;
        #1;
        chk_reset_outs();
        b_hold = 0;
        tick(); tick();
        ARESETN = 1;
        r0 = aw_rise;
        repeat (5) tick();
        chk("no_retry", 64'(aw_rise), 64'(r0));
        chk("no_retry_busy", 64'(busy), 64'd0);
        run(300, 400, 10, 0, 3, 0, 0, 0);
        chk("post_rst_first", 64'(wq[0]), 64'd300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
